// File: rtl/mfunc_reg_bank.sv
// mfunc_reg_bank: parametrised control/status register bank.
//   - NUM_RW byte-enabled read/write control words with per-word reset values
//   - NUM_RO read-only status words, each bit through SYNC_STAGES flops
//   - write-1-to-clear interrupt status, enable mask and registered irq
//   - self-clearing command pulse register
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en/rd_en, addr   access strobes and shared byte address
//   wr_data, wr_be      write data and byte enables
//   rd_data/rd_valid/rd_err   registered read response (one cycle after rd_en)
//   wr_err              pulse after a write to an unmapped or read-only address
//   rw_q                flattened RW register contents
//   ro_in               status inputs, may be asynchronous
//   irq_src, irq        level interrupt sources, registered interrupt request
//   cmd_pulse           one-cycle command bits
// Map (word aligned): RW 0x000+4i, RO 0x100+4j, IRQ_STAT 0x200,
//   IRQ_EN 0x204, CMD 0x208.

// One byte-enabled RW control word.
module mfunc_rw_word #(
  parameter int               DATA_W = 32,
  parameter logic [DATA_W-1:0] RST   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] be_mask,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= RST;
    else if (we) q <= (q & ~be_mask) | (wdata & be_mask);
  end
endmodule

module mfunc_reg_bank #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int NUM_RW      = 4,
  parameter int NUM_RO      = 2,
  parameter int IRQ_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_RW*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic                     wr_err,
  output logic [NUM_RW*DATA_W-1:0] rw_q,
  // With NUM_RO=0 a single dummy word keeps the port width legal.
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_W-1:0] ro_in,
  input  logic [IRQ_W-1:0]         irq_src,
  output logic                     irq,
  output logic [DATA_W-1:0]        cmd_pulse
);
  localparam int BE_W  = DATA_W / 8;
  localparam int WA    = ADDR_W - 2;
  localparam int RO_BW = ((NUM_RO > 0) ? NUM_RO : 1) * DATA_W;

  // Word-index decode constants (byte address >> 2).
  localparam logic [WA-1:0] W_RW_END = WA'(NUM_RW);
  localparam logic [WA-1:0] W_RO     = WA'(64);
  localparam logic [WA-1:0] W_RO_END = WA'(64 + NUM_RO);
  localparam logic [WA-1:0] W_STAT   = WA'(128);
  localparam logic [WA-1:0] W_EN     = WA'(129);
  localparam logic [WA-1:0] W_CMD    = WA'(130);

  logic [WA-1:0]     word;
  logic              addr_unused;
  logic              hit_rw, hit_ro, hit_stat, hit_en, hit_cmd, mapped;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] rd_mux;

  logic [SYNC_STAGES-1:0][RO_BW-1:0] ro_sync;
  logic [IRQ_W-1:0]  irq_prev, irq_stat, irq_en, irq_clr;

  assign word        = addr[ADDR_W-1:2];
  assign addr_unused = ^addr[1:0];

  assign hit_rw   = (word < W_RW_END);
  assign hit_ro   = (word >= W_RO) && (word < W_RO_END);
  assign hit_stat = (word == W_STAT);
  assign hit_en   = (word == W_EN);
  assign hit_cmd  = (word == W_CMD);
  assign mapped   = hit_rw | hit_ro | hit_stat | hit_en | hit_cmd;

  genvar gb;
  generate
    for (gb = 0; gb < BE_W; gb++) begin : g_be
      assign be_mask[gb*8 +: 8] = {8{wr_be[gb]}};
    end
  endgenerate

  // RW control words
  genvar gr;
  generate
    for (gr = 0; gr < NUM_RW; gr++) begin : g_rw
      mfunc_rw_word #(
        .DATA_W (DATA_W),
        .RST    (RST_VAL[gr*DATA_W +: DATA_W])
      ) u_word (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en && (word == WA'(gr))),
        .be_mask (be_mask),
        .wdata   (wr_data),
        .q       (rw_q[gr*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // RO synchroniser chain; the last stage is what software reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ro_sync <= '0;
    end else begin
      ro_sync[0] <= ro_in;
      for (int s = 1; s < SYNC_STAGES; s++) ro_sync[s] <= ro_sync[s-1];
    end
  end

  // Interrupts: edge detect on irq_src; a new edge beats a same-cycle W1C.
  assign irq_clr = (wr_en && hit_stat) ? (wr_data[IRQ_W-1:0] & be_mask[IRQ_W-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= '0;
      irq_stat <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      irq_prev <= irq_src;
      irq_stat <= (irq_stat & ~irq_clr) | (irq_src & ~irq_prev);
      if (wr_en && hit_en)
        irq_en <= (irq_en & ~be_mask[IRQ_W-1:0]) | (wr_data[IRQ_W-1:0] & be_mask[IRQ_W-1:0]);
      irq      <= |(irq_stat & irq_en);
    end
  end

  // Command pulses last exactly the cycle after the write.
  always_ff @(posedge clk) begin
    if (rst)                     cmd_pulse <= '0;
    else if (wr_en && hit_cmd)   cmd_pulse <= wr_data & be_mask;
    else                         cmd_pulse <= '0;
  end

  // Read mux sees pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (word == WA'(i)) rd_mux = rw_q[i*DATA_W +: DATA_W];
    for (int j = 0; j < NUM_RO; j++)
      if (word == WA'(64 + j)) rd_mux = ro_sync[SYNC_STAGES-1][j*DATA_W +: DATA_W];
    if (hit_stat) rd_mux = DATA_W'(irq_stat);
    if (hit_en)   rd_mux = DATA_W'(irq_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & ~mapped;
      if (rd_en) rd_data <= rd_mux;
      wr_err   <= wr_en & (~mapped | hit_ro);
    end
  end

endmodule

// File: tb/tb_mfunc_reg_bank.sv
// Directed bench for mfunc_reg_bank: reset values, byte-enabled RW writes,
// read-before-write, RO synchronisation latency, interrupt edge/W1C/set-wins,
// command pulses, unmapped accesses and reset during a read.
module tb_mfunc_reg_bank;
  localparam int ADDR_W = 12, DATA_W = 32, NUM_RW = 4, NUM_RO = 2;
  localparam int IRQ_W = 8, SYNC_STAGES = 2;
  localparam logic [127:0] RST_VAL = {32'h1, 32'h2, 32'h3, 32'h0};

  logic         clk = 1'b0;
  logic         rst, wr_en, rd_en;
  logic [11:0]  addr;
  logic [31:0]  wr_data;
  logic [3:0]   wr_be;
  logic [31:0]  rd_data;
  logic         rd_valid, rd_err, wr_err;
  logic [127:0] rw_q;
  logic [63:0]  ro_in;
  logic [7:0]   irq_src;
  logic         irq;
  logic [31:0]  cmd_pulse;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mfunc_reg_bank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .IRQ_W(IRQ_W), .SYNC_STAGES(SYNC_STAGES), .RST_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .wr_err(wr_err), .rw_q(rw_q), .ro_in(ro_in),
    .irq_src(irq_src), .irq(irq), .cmd_pulse(cmd_pulse)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    rd_en = 1'b1; addr = a;
    tick;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; addr = a; wr_data = d; wr_be = be;
    tick;
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0; wr_be = '0;
    irq_src = '0;
    ro_in = {32'h0000CAFE, 32'h00001111};
    tick; tick;

    // reset state
    chk("rst_rwq", rw_q, RST_VAL);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cmd", cmd_pulse, 32'h0);
    chk("rst_werr", wr_err, 1'b0);
    rst = 1'b0;
    tick;

    // reset value readback, then hold behaviour
    rd(12'h004);
    chk("rd4_v", rd_valid, 1'b1);
    chk("rd4_d", rd_data, 32'h3);
    chk("rd4_e", rd_err, 1'b0);
    tick;
    chk("hold_v", rd_valid, 1'b0);
    chk("hold_d", rd_data, 32'h3);

    // same-cycle write and read of RW0: read sees pre-write value
    wr_en = 1'b1; rd_en = 1'b1; addr = 12'h000; wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    tick;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rwr_old", rd_data, 32'h0);
    chk("rwr_v", rd_valid, 1'b1);
    chk("rwr_q", rw_q[31:0], 32'h00BB00DD);
    rd(12'h000);
    chk("rw0_new", rd_data, 32'h00BB00DD);

    // RO sync latency: value changes in the first read cycle
    ro_in[31:0] = 32'h00005A5A;
    rd_en = 1'b1; addr = 12'h100;
    tick; chk("ro_c1", rd_data, 32'h1111);
    tick; chk("ro_c2", rd_data, 32'h1111);
    tick; chk("ro_c3", rd_data, 32'h5A5A);
    rd_en = 1'b0;
    rd(12'h104);
    chk("ro1", rd_data, 32'hCAFE);
    wr(12'h100, 32'hFFFFFFFF, 4'hF);
    chk("ro_werr", wr_err, 1'b1);
    tick;
    chk("ro_werr0", wr_err, 1'b0);
    rd(12'h100);
    chk("ro_keep", rd_data, 32'h5A5A);
    chk("ro_rwq", rw_q, {32'h1, 32'h2, 32'h3, 32'h00BB00DD});

    // interrupt enable: only low IRQ_W bits stored
    wr(12'h204, 32'hFFFFFF01, 4'hF);
    rd(12'h204);
    chk("irqen", rd_data, 32'h1);

    // rising edge sets status; irq follows one cycle later
    irq_src = 8'h01;
    tick;
    chk("irq_lag", irq, 1'b0);
    rd(12'h200);
    chk("stat_set", rd_data, 32'h1);
    chk("irq_on", irq, 1'b1);

    // W1C with source still high: clears, no re-set
    wr(12'h200, 32'h1, 4'h1);
    chk("irq_w1c_lag", irq, 1'b1);
    tick;
    chk("irq_off", irq, 1'b0);
    rd(12'h200);
    chk("stat_clr", rd_data, 32'h0);

    // clear and new edge in the same cycle: set wins
    irq_src = 8'h00;
    tick;
    irq_src = 8'h01;
    wr(12'h200, 32'h1, 4'h1);
    rd(12'h200);
    chk("set_wins", rd_data, 32'h1);
    chk("irq_sw", irq, 1'b1);

    // command pulses: back-to-back, then masked by byte enables
    wr_en = 1'b1; addr = 12'h208; wr_data = 32'h81; wr_be = 4'hF;
    tick; chk("cmd_p1", cmd_pulse, 32'h81);
    tick; chk("cmd_p2", cmd_pulse, 32'h81);
    wr_en = 1'b0;
    tick; chk("cmd_p0", cmd_pulse, 32'h0);
    wr(12'h208, 32'h0000FF81, 4'b0001);
    chk("cmd_be", cmd_pulse, 32'h81);
    tick; chk("cmd_be0", cmd_pulse, 32'h0);
    rd(12'h208);
    chk("cmd_rd", rd_data, 32'h0);
    chk("cmd_rde", rd_err, 1'b0);

    // unmapped accesses and map boundaries
    rd(12'h3F0);
    chk("un_v", rd_valid, 1'b1);
    chk("un_e", rd_err, 1'b1);
    chk("un_d", rd_data, 32'h0);
    rd(12'h108);
    chk("ro_end_e", rd_err, 1'b1);
    rd(12'h010);
    chk("rw_end_e", rd_err, 1'b1);
    wr(12'h3F0, 32'h12345678, 4'hF);
    chk("un_werr", wr_err, 1'b1);
    wr(12'h00C, 32'h12345678, 4'hF);
    chk("rw3_werr", wr_err, 1'b0);
    chk("rw3_q", rw_q[127:96], 32'h12345678);

    // reset during a read: access dropped, everything back to reset values
    wr(12'h008, 32'hDEADBEEF, 4'hF);
    rst = 1'b1; rd_en = 1'b1; addr = 12'h004;
    tick;
    rst = 1'b0; rd_en = 1'b0;
    chk("rr_v", rd_valid, 1'b0);
    chk("rr_e", rd_err, 1'b0);
    chk("rr_d", rd_data, 32'h0);
    chk("rr_q", rw_q, RST_VAL);
    chk("rr_irq", irq, 1'b0);
    chk("rr_cmd", cmd_pulse, 32'h0);
    tick;
    chk("rr_v2", rd_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
